// File: rtl/pipe_ctrl_pkg.sv
// Shared types and sizing helpers for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {RUN, DWAIT, ERR} state_t;

  // Wait counter must hold values up to MEM_TIMEOUT; never narrower than one bit.
  function automatic int wait_cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

  localparam int MEM_TIMEOUT_DEF = 16;
  localparam int WAIT_W_DEF      = wait_cnt_w(MEM_TIMEOUT_DEF);

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stall/flush/status outputs between pipeline and controller.
interface pipeline_ctrl_if #(parameter int CNT_W = 32);
  logic             ResultSrcE0;
  logic [4:0]       RD_E;
  logic [4:0]       RS1_D;
  logic [4:0]       RS2_D;
  logic             PCSrcE;
  logic             InstrValidF;
  logic             MemReqM;
  logic             MemReadyM;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             StallE;
  logic             FlushE;
  logic             StallM;
  logic             FlushW;
  logic             BusErr;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output ResultSrcE0, RD_E, RS1_D, RS2_D, PCSrcE, InstrValidF, MemReqM, MemReadyM,
    input  StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW, BusErr,
           StallCount, FlushCount
  );

  modport slave (
    input  ResultSrcE0, RD_E, RS1_D, RS2_D, PCSrcE, InstrValidF, MemReqM, MemReadyM,
    output StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW, BusErr,
           StallCount, FlushCount
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)                      count <= '0;
    else if (inc && count != '1)  count <= count + W'(1);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: load-use, redirect, slow I-mem and slow D-mem hazards,
// with a D-mem timeout watchdog and saturating stall/flush cycle counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);

  localparam int WW = wait_cnt_w(MEM_TIMEOUT);

  state_t        state, state_n;
  logic [WW-1:0] wait_cnt;
  logic          mem_miss, lw_stall, timeout_hit;
  logic          stall_f, stall_d, stall_e, stall_m;
  logic          flush_d, flush_e, flush_w;

  assign mem_miss = bus.MemReqM & ~bus.MemReadyM;
  assign lw_stall = bus.ResultSrcE0 & (bus.RD_E != 5'd0) &
                    ((bus.RD_E == bus.RS1_D) | (bus.RD_E == bus.RS2_D));
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_miss &&
                       (wait_cnt == WW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      // Counts consecutive miss edges; saturating so ERR with a stuck bus cannot wrap it.
      if (!mem_miss)             wait_cnt <= '0;
      else if (wait_cnt != '1)   wait_cnt <= wait_cnt + WW'(1);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      RUN:     if (mem_miss) state_n = DWAIT;
      DWAIT:   if (bus.MemReadyM) state_n = RUN;
               else if (timeout_hit) state_n = ERR;
      ERR:     state_n = ERR;
      default: state_n = RUN;
    endcase
  end

  // Priority: reset, ERR, D-mem miss, redirect, load-use, I-mem not ready.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (state == ERR || mem_miss) begin
      // Full freeze; a pending redirect is held in E and acted on after release.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (bus.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else if (!bus.InstrValidF) begin
      stall_f = 1'b1;
      flush_d = 1'b1;
    end
  end

  assign bus.StallF = stall_f;
  assign bus.StallD = stall_d;
  assign bus.StallE = stall_e;
  assign bus.StallM = stall_m;
  assign bus.FlushD = flush_d;
  assign bus.FlushE = flush_e;
  assign bus.FlushW = flush_w;
  assign bus.BusErr = (state == ERR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_f),
    .count (bus.StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_e),
    .count (bus.FlushCount)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed hazard scenarios followed by randomized traffic, all checked against a
// cycle-level behavioural model of the controller's rules.
module tb_pipeline_ctrl;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  // Model state: sticky error, length of the current run of consecutive miss edges, counters.
  bit   m_err;
  int   m_miss_len;
  int   m_stall_cnt, m_flush_cnt;
  int   burst_left;
  bit   in_burst;

  pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW}
  function automatic logic [6:0] model_ctrl();
    bit miss, lw;
    miss = bus.MemReqM && !bus.MemReadyM;
    lw   = bus.ResultSrcE0 && bus.RD_E != 0 && (bus.RD_E == bus.RS1_D || bus.RD_E == bus.RS2_D);
    if (rst)                 return 7'b0010101;
    if (m_err || miss)       return 7'b1101011;
    if (bus.PCSrcE)          return 7'b0010100;
    if (lw)                  return 7'b1100100;
    if (!bus.InstrValidF)    return 7'b1010000;
    return 7'b0000000;
  endfunction

  function automatic void model_edge(input logic [6:0] ctl);
    bit miss;
    miss = bus.MemReqM && !bus.MemReadyM;
    if (rst) begin
      m_err = 0; m_miss_len = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      if (miss && m_miss_len == TIMEOUT - 1) m_err = 1;
      m_miss_len = miss ? m_miss_len + 1 : 0;
      if (ctl[6] && m_stall_cnt < CMAX) m_stall_cnt++;
      if (ctl[2] && m_flush_cnt < CMAX) m_flush_cnt++;
    end
  endfunction

  task automatic step(input string tag);
    logic [6:0] exp_v, got_v;
    @(negedge clk);
    exp_v = model_ctrl();
    got_v = {bus.StallF, bus.StallD, bus.FlushD, bus.StallE, bus.FlushE, bus.StallM, bus.FlushW};
    checks++;
    assert (got_v === exp_v) else begin
      failures++; $error("FAIL %s ctrl got=%b exp=%b", tag, got_v, exp_v);
    end
    checks++;
    assert (bus.BusErr === m_err) else begin
      failures++; $error("FAIL %s BusErr got=%b exp=%b", tag, bus.BusErr, m_err);
    end
    checks++;
    assert (bus.StallCount === CNT_W'(m_stall_cnt)) else begin
      failures++; $error("FAIL %s StallCount got=%0d exp=%0d", tag, bus.StallCount, m_stall_cnt);
    end
    checks++;
    assert (bus.FlushCount === CNT_W'(m_flush_cnt)) else begin
      failures++; $error("FAIL %s FlushCount got=%0d exp=%0d", tag, bus.FlushCount, m_flush_cnt);
    end
    @(posedge clk);
    model_edge(exp_v);
    #1;
  endtask

  task automatic idle();
    bus.ResultSrcE0 = 0; bus.RD_E = 0; bus.RS1_D = 0; bus.RS2_D = 0;
    bus.PCSrcE = 0; bus.InstrValidF = 1; bus.MemReqM = 0; bus.MemReadyM = 0;
  endtask

  initial begin
    rst = 1; idle();
    m_err = 0; m_miss_len = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    in_burst = 0; burst_left = 0;
    repeat (2) @(posedge clk);
    #1;
    step("reset_hold");
    rst = 0;
    step("idle");

    // Load-use hit, then the same pattern targeting x0.
    bus.ResultSrcE0 = 1; bus.RD_E = 5; bus.RS2_D = 5;
    step("load_use");
    step("load_use_cnt");
    bus.RD_E = 0; bus.RS2_D = 0;
    step("load_use_x0");

    // Redirect overrides load-use and I-mem stall.
    bus.RD_E = 7; bus.RS1_D = 7; bus.PCSrcE = 1; bus.InstrValidF = 0;
    step("redirect_over_all");
    // Load-use with I-mem not ready: D held, not flushed.
    bus.PCSrcE = 0;
    step("lw_and_imiss");
    idle(); bus.InstrValidF = 0;
    step("imiss");

    // D-mem wait with a pending redirect, released on cycle 4.
    idle(); bus.PCSrcE = 1; bus.MemReqM = 1;
    repeat (3) step("dwait_redirect");
    bus.MemReadyM = 1;
    step("dwait_release");
    idle();
    step("after_release");

    // Watchdog: 16 miss cycles, ERR from 17th, sticky through ready.
    bus.MemReqM = 1;
    repeat (16) step("timeout_wait");
    step("timeout_err");
    bus.MemReadyM = 1; bus.PCSrcE = 1;
    step("err_sticky");
    checks++;
    assert (bus.BusErr === 1'b1) else begin
      failures++; $error("FAIL err_flag got=%b exp=1", bus.BusErr);
    end
    rst = 1; idle();
    step("err_reset");
    rst = 0;
    step("after_err_reset");

    // Reset in the middle of a D-mem wait.
    bus.MemReqM = 1;
    repeat (2) step("mid_dwait");
    rst = 1;
    step("mid_dwait_rst");
    rst = 0; idle();
    step("after_mid_rst");

    // Saturation of the stall counter.
    bus.InstrValidF = 0;
    repeat (20) step("saturate");
    checks++;
    assert (bus.StallCount === CNT_W'(CMAX)) else begin
      failures++; $error("FAIL saturate_final got=%0d exp=%0d", bus.StallCount, CMAX);
    end
    rst = 1; idle();
    step("pre_random_rst");
    rst = 0;

    // Randomized traffic with memory bursts long enough to occasionally time out.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 39) == 0) || (m_err && $urandom_range(0, 7) == 0);
      bus.ResultSrcE0 = 1'($urandom_range(0, 1));
      bus.RD_E        = 5'($urandom_range(0, 3));
      bus.RS1_D       = 5'($urandom_range(0, 3));
      bus.RS2_D       = 5'($urandom_range(0, 3));
      bus.PCSrcE      = ($urandom_range(0, 3) == 0);
      bus.InstrValidF = ($urandom_range(0, 3) != 0);
      if (!in_burst && $urandom_range(0, 5) == 0) begin
        in_burst   = 1;
        burst_left = $urandom_range(0, 20);
      end
      if (in_burst) begin
        bus.MemReqM   = 1;
        bus.MemReadyM = (burst_left == 0);
        if (burst_left == 0) in_burst = 0;
        else burst_left--;
      end else begin
        bus.MemReqM   = 0;
        bus.MemReadyM = 1'($urandom_range(0, 1));
      end
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
